// File: rtl/priority_arbiter_ctrl.sv
// Registered one-hot arbiter: highest requester wins, grant held until release or MAX_HOLD,
// then one idle turnaround cycle. Define ROUND_ROBIN_EN to rotate priority past the last grantee.
module priority_arbiter_ctrl #(
  parameter int N        = 8,
  parameter int IDW      = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);
  localparam int HCW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_gnt_id, w_gnt_id_nxt;
  logic           r_gnt_valid, w_gnt_valid_nxt;
  logic           r_timeout, w_timeout_nxt;
  logic [HCW-1:0] r_hold_cnt, w_hold_nxt;
  logic           w_win_vld;
  logic [IDW-1:0] w_win_id;

`ifdef ROUND_ROBIN_EN
  logic [IDW-1:0] r_rr_ptr;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int p);
    int t;
    t = int'(ptr) + N - p;
    if (t >= N) t = t - N;
    return IDW'(t);
  endfunction

  // Walk from lowest priority (rr_ptr) to highest (rr_ptr-1); the last hit wins.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    for (int p = N; p >= 1; p--) begin
      if (req[rr_idx(r_rr_ptr, p)]) begin
        w_win_vld = 1'b1;
        w_win_id  = rr_idx(r_rr_ptr, p);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
    end else if (r_state != S_GRANT && w_win_vld) begin
      r_rr_ptr <= w_win_id;
    end
  end
`else
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        w_win_vld = 1'b1;
        w_win_id  = IDW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      r_hold_cnt  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_timeout_nxt   = 1'b0;
    w_hold_nxt      = r_hold_cnt;
    case (r_state)
      S_IDLE, S_RELEASE: begin
        w_state_nxt     = S_IDLE;
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
        if (w_win_vld) begin
          w_state_nxt     = S_GRANT;
          w_gnt_nxt       = N'(1) << w_win_id;
          w_gnt_id_nxt    = w_win_id;
          w_gnt_valid_nxt = 1'b1;
          w_hold_nxt      = '0;
        end
      end
      S_GRANT: begin
        // Owner release takes precedence over a coincident timeout.
        if (!req[r_gnt_id]) begin
          w_state_nxt     = S_RELEASE;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
        end else if (r_hold_cnt == HCW'(MAX_HOLD - 1)) begin
          w_state_nxt     = S_RELEASE;
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_timeout_nxt   = 1'b1;
        end else begin
          w_hold_nxt = r_hold_cnt + HCW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
